// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_param.
// The master side drives requests; the slave (the FIFO) returns data, status and errors.
interface sync_fifo_param_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
);
  localparam int AW = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              full_flag;
  logic              empty_flag;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       fifo_count;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output wr_en, data_in, rd_en, err_clr,
    input  data_out, rd_valid, full_flag, empty_flag, almost_full, almost_empty,
           fifo_count, overflow_err, underflow_err
  );

  modport slave (
    input  wr_en, data_in, rd_en, err_clr,
    output data_out, rd_valid, full_flag, empty_flag, almost_full, almost_empty,
           fifo_count, overflow_err, underflow_err
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 64,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 60,
  parameter int AE_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              full, empty, wr_acc, rd_acc;

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign wr_acc = f.wr_en & ~full;
  assign rd_acc = f.rd_en & ~empty;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
    // A fresh error event in the same cycle overrides the clear.
    if (f.err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (f.wr_en && full)  ovf_d = 1'b1;
    if (f.rd_en && empty) udf_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define validity, and this keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= f.data_in;
  end

  if (FWFT == 0) begin : g_std
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;

    always_comb begin
      data_out_d = data_out_q;
      rd_valid_d = rd_acc;
      if (rd_acc) data_out_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_out_q <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        data_out_q <= data_out_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign f.data_out = data_out_q;
    assign f.rd_valid = rd_valid_q;
  end else begin : g_fwft
    // Head word is shown straight from the array once it has been written.
    assign f.data_out = empty ? '0 : mem_q[rd_ptr_q];
    assign f.rd_valid = ~empty;
  end

  assign f.full_flag     = full;
  assign f.empty_flag    = empty;
  assign f.almost_full   = (count_q >= AF_C);
  assign f.almost_empty  = (count_q <= AE_C);
  assign f.fifo_count    = count_q;
  assign f.overflow_err  = ovf_q;
  assign f.underflow_err = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a standard-read and an FWFT instance with identical stimulus and checks both
// against a queue model of the FIFO contents, flags and sticky errors.
module tb_sync_fifo_param;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] data_in = '0;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout = '0;
  logic          exp_rv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  string         stage = "init";

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus_std ();
  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus_fw ();

  assign bus_std.wr_en   = wr_en;
  assign bus_std.data_in = data_in;
  assign bus_std.rd_en   = rd_en;
  assign bus_std.err_clr = err_clr;
  assign bus_fw.wr_en    = wr_en;
  assign bus_fw.data_in  = data_in;
  assign bus_fw.rd_en    = rd_en;
  assign bus_fw.err_clr  = err_clr;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE))
    dut_std (.clk(clk), .rst(rst), .f(bus_std.slave));
  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE))
    dut_fw (.clk(clk), .rst(rst), .f(bus_fw.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    check({stage, "_count"},      32'(bus_std.fifo_count),   32'(n));
    check({stage, "_empty"},      32'(bus_std.empty_flag),   32'(n == 0));
    check({stage, "_full"},       32'(bus_std.full_flag),    32'(n == DEPTH));
    check({stage, "_afull"},      32'(bus_std.almost_full),  32'(n >= AF));
    check({stage, "_aempty"},     32'(bus_std.almost_empty), 32'(n <= AE));
    check({stage, "_ovf"},        32'(bus_std.overflow_err), 32'(m_ovf));
    check({stage, "_udf"},        32'(bus_std.underflow_err),32'(m_udf));
    check({stage, "_std_dout"},   32'(bus_std.data_out),     32'(exp_dout));
    check({stage, "_std_valid"},  32'(bus_std.rd_valid),     32'(exp_rv));
    check({stage, "_fw_count"},   32'(bus_fw.fifo_count),    32'(n));
    check({stage, "_fw_dout"},    32'(bus_fw.data_out),      (n > 0) ? 32'(q[0]) : 32'h0);
    check({stage, "_fw_valid"},   32'(bus_fw.rd_valid),      32'(n > 0));
    check({stage, "_fw_ovf"},     32'(bus_fw.overflow_err),  32'(m_ovf));
    check({stage, "_fw_udf"},     32'(bus_fw.underflow_err), 32'(m_udf));
  endtask

  // One clock of stimulus; the model updates from the pre-edge state, outputs are checked 1ns after the edge.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    logic was_full, was_empty;
    wr_en = w; data_in = d; rd_en = r; err_clr = c;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk); #1;
    exp_rv = r && !was_empty;
    if (exp_rv) exp_dout = q.pop_front();
    if (w && !was_full) q.push_back(d);
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (w && was_full)  m_ovf = 1'b1;
    if (r && was_empty) m_udf = 1'b1;
    check_all();
  endtask

  task automatic reset_cycle(input logic w, input logic r);
    rst = 1'b1; wr_en = w; rd_en = r; data_in = 16'hDEAD; err_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    exp_dout = '0; exp_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    check_all();
  endtask

  initial begin
    // T1: reset then three writes and three reads
    stage = "t1_reset";
    reset_cycle(1'b0, 1'b0);
    reset_cycle(1'b0, 1'b0);
    stage = "t1_basic";
    cycle(1'b1, 16'h1111, 1'b0, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0, 1'b0);
    cycle(1'b1, 16'h3333, 1'b0, 1'b0);
    check("t1_count3", 32'(bus_std.fifo_count), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("t1_last_dout", 32'(bus_std.data_out), 32'h3333);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("t1_end_empty", 32'(bus_std.empty_flag), 32'd1);

    // T2: fill past full, 0x0009 must be dropped
    stage = "t2_fill";
    for (int i = 1; i <= 9; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    check("t2_full_count", 32'(bus_std.fifo_count), 32'd8);
    check("t2_ovf", 32'(bus_std.overflow_err), 32'd1);
    stage = "t2_drain";
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("t2_last_dout", 32'(bus_std.data_out), 32'h0008);
    stage = "t2_clr";
    cycle(1'b0, '0, 1'b0, 1'b1);

    // T3: sustained read+write at count 4, then both at full
    stage = "t3_prefill";
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
    stage = "t3_stream";
    for (int i = 0; i < 20; i++) cycle(1'b1, DW'(16'h0200 + i), 1'b1, 1'b0);
    check("t3_stream_count", 32'(bus_std.fifo_count), 32'd4);
    stage = "t3_topup";
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(16'h0300 + i), 1'b0, 1'b0);
    stage = "t3_full_both";
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    check("t3_full_both_count", 32'(bus_std.fifo_count), 32'd7);
    check("t3_full_both_ovf", 32'(bus_std.overflow_err), 32'd1);
    stage = "t3_drain";
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // T4: underflow, clear, clear racing a new underflow, empty with read+write
    stage = "t4_udf";
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t4_udf_set", 32'(bus_std.underflow_err), 32'd1);
    stage = "t4_clr";
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t4_udf_cleared", 32'(bus_std.underflow_err), 32'd0);
    stage = "t4_clr_race";
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("t4_udf_wins", 32'(bus_std.underflow_err), 32'd1);
    stage = "t4_empty_both";
    cycle(1'b1, 16'h4444, 1'b1, 1'b1);
    check("t4_empty_both_count", 32'(bus_std.fifo_count), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("t4_ptr_intact", 32'(bus_std.data_out), 32'h4444);

    // T5: FWFT fall-through and pop
    stage = "t5_fwft";
    cycle(1'b1, 16'hABCD, 1'b0, 1'b0);
    check("t5_fw_show", 32'(bus_fw.data_out), 32'hABCD);
    check("t5_fw_valid", 32'(bus_fw.rd_valid), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t5_fw_popped", 32'(bus_fw.data_out), 32'h0);

    // T6: reset mid-stream with concurrent read and write
    stage = "t6_fill";
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(16'h0600 + i), 1'b0, 1'b0);
    stage = "t6_rst";
    reset_cycle(1'b1, 1'b1);
    check("t6_rst_count", 32'(bus_std.fifo_count), 32'd0);
    check("t6_rst_dout", 32'(bus_std.data_out), 32'd0);
    stage = "t6_after";
    cycle(1'b1, 16'h7777, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic against the model
    stage = "rand";
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
